// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and helpers for the pipelined adder
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational ripple-carry slice built from full-adder cells
module adder_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [SW:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        logic p;
        assign p          = a[i] ^ b[i];
        assign sum[i]     = p ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (p & carry[i]);
    end

    assign cout = carry[SW];
    // carry into the top bit; xor with cout gives signed overflow
    assign cmsb = carry[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-pipelined add/subtract with valid/ready flow control
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic stall;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] ovf_q,   ovf_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic [SW-1:0]     sl_a  [STAGES];
    logic [SW-1:0]     sl_b  [STAGES];
    logic [SW-1:0]     sl_s  [STAGES];
    logic [STAGES-1:0] sl_ci;
    logic [STAGES-1:0] sl_co;
    logic [STAGES-1:0] sl_cm;

    logic [WIDTH-1:0]  b_eff;
    logic              c_first;

    // subtraction folds into addition of ~b with a forced carry-in
    assign b_eff   = (sub == MODE_SUB) ? ~b : b;
    assign c_first = (sub == MODE_SUB) ? 1'b1 : cin;

    assign stall    = valid_q[STAGES-1] & ~out_ready & ~rst;
    assign in_ready = ~stall;

    always_comb begin
        sl_a[0]  = a[SW-1:0];
        sl_b[0]  = b_eff[SW-1:0];
        sl_ci[0] = c_first;
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]  = a_q[k-1][k*SW +: SW];
            sl_b[k]  = b_q[k-1][k*SW +: SW];
            sl_ci[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a   (sl_a[k]),
            .b   (sl_b[k]),
            .cin (sl_ci[k]),
            .sum (sl_s[k]),
            .cout(sl_co[k]),
            .cmsb(sl_cm[k])
        );
    end

    // Upper operand slices ride along (skew) and finished low slices ride along (deskew)
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        if (!stall) begin
            valid_d[0]         = in_valid;
            a_d[0]             = a;
            b_d[0]             = b_eff;
            sum_d[0]           = '0;
            sum_d[0][SW-1:0]   = sl_s[0];
            carry_d[0]         = sl_co[0];
            ovf_d[0]           = sl_co[0] ^ sl_cm[0];
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k]            = valid_q[k-1];
                a_d[k]                = a_q[k-1];
                b_d[k]                = b_q[k-1];
                sum_d[k]              = sum_q[k-1];
                sum_d[k][k*SW +: SW]  = sl_s[k];
                carry_d[k]            = sl_co[k];
                ovf_d[k]              = sl_co[k] ^ sl_cm[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder against an arithmetic reference model
module tb_pipe_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipe_adder #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W+1:0] exp_q [$];
    int           acc_q [$];
    logic [W+1:0] dir_q [$];

    bit           lat_chk   = 1'b0;
    bit           stall_ph  = 1'b0;
    int           stall_cnt = 0;
    bit           prev_stall = 1'b0;
    logic [W+1:0] held;
    int           post_rst_valid = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // {cout, ovf, sum} straight from the arithmetic definition
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         o;
        be = ms ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, be} + ((ms ? 1'b1 : mc) ? 17'd1 : 17'd0);
        o  = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
        return {t[W], o, t[W-1:0]};
    endfunction

    always @(negedge clk) begin
        logic [W+1:0] e;
        int           t0;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_vs_stall", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall)
                chk("stall_hold", {45'd0, out_valid, cout, ovf, sum}, {45'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                chk("out_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    t0 = acc_q.pop_front();
                    chk("result", {46'd0, cout, ovf, sum}, {46'd0, e});
                    if (lat_chk) chk("latency", 64'(cyc - t0), 64'(S));
                    if (dir_q.size() != 0) chk("directed", {46'd0, cout, ovf, sum}, {46'd0, dir_q.pop_front()});
                end
            end
            if (stall_ph && !in_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            held       = {cout, ovf, sum};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int  guard;
        bit  acc;
        guard = 0;
        in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("send_timeout", 64'(guard), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [W-1:0] corner [5];

    function automatic logic [W-1:0] pick();
        int r;
        r = $urandom_range(0, 7);
        if (r < 5) return corner[r] ^ ((r == 4) ? W'($urandom) : '0);
        return W'($urandom);
    endfunction

    initial begin
        bit pending;
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
        corner[3] = 16'h8000; corner[4] = 16'h0000;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {45'd0, out_valid, cout, ovf, sum}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;

        // directed vectors with fixed expectations and latency check
        lat_chk = 1'b1;
        dir_q.push_back({1'b1, 1'b0, 16'h0000}); send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        dir_q.push_back({1'b0, 1'b1, 16'h8000}); send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        dir_q.push_back({1'b0, 1'b0, 16'h1236}); send(16'h1234, 16'h0001, 1'b1, 1'b0);
        dir_q.push_back({1'b0, 1'b0, 16'hFFFE}); send(16'h0005, 16'h0007, 1'b1, 1'b1);
        dir_q.push_back({1'b1, 1'b1, 16'h7FFF}); send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();
        chk("directed_consumed", 64'(dir_q.size()), 64'd0);
        lat_chk = 1'b0;

        // ten back-to-back with a three-cycle consumer stall
        stall_ph = 1'b1; stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16'(i * 16'h1111), 16'(16'h0F0F + i), i[0], i[1]);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        stall_ph = 1'b0;
        chk("stall_cycles", 64'(stall_cnt), 64'd3);

        // reset with three transactions in flight
        for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i), 16'h0002, 1'b0, 1'b0);
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_during_rst", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("after_rst_state", {45'd0, out_valid, cout, ovf, sum}, 64'd0);
        chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0; out_ready = 1'b1;
        post_rst_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) post_rst_valid++;
        end
        chk("no_stale_results", 64'(post_rst_valid), 64'd0);

        // randomized traffic with random back-pressure
        pending = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10000; i++) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                in_valid = ($urandom_range(0, 2) != 0);
                a   = pick();
                b   = pick();
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            pending = in_valid && !in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES, checked at elaboration.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operand set presented.
REQ-006 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: result presented.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out (add) or not-borrow (sub).
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 Add: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-017 Sub: {cout,sum} SHALL equal a + ~b + 1; cout=1 means no borrow (a >= b unsigned).
REQ-018 ovf SHALL be 1 iff the sign bits of a and the effective b (b or ~b) are equal and differ from sum[WIDTH-1].
REQ-019 Operands SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k adds slice k using the carry registered by stage k-1 (stage 0 uses cin, or 1 when sub=1).
REQ-020 Upper operand slices SHALL be skewed through delay registers; lower result slices deskewed, so all result bits of one transaction emerge together.
REQ-021 Latency SHALL be exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, when out_ready is held high.
REQ-022 Throughput SHALL be one transaction per cycle when out_ready is held high.
REQ-023 Stall = out_valid & ~out_ready; on stall the entire pipeline, including valid bits, SHALL hold.
REQ-024 in_ready SHALL equal ~stall (combinational from out_ready); transactions SHALL never be dropped, duplicated or reordered.
REQ-025 sum/cout/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Bubbles (in_valid=0 on an accepted cycle) SHALL propagate as out_valid=0 slots, without altering neighbouring results.
REQ-027 in_valid with in_ready=0 SHALL have no effect; the source holds a, b, cin and sub.

Reset
REQ-028 When rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 after that edge.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions; no result from before reset SHALL appear after it.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 rst SHALL take priority over stall and input acceptance in the same cycle.

Structure
REQ-032 Package pipe_adder_pkg SHALL hold default WIDTH/STAGES constants, the SUB/ADD mode constants and the derived SLICE_W = WIDTH/STAGES function.
REQ-033 One sub-module, adder_slice (combinational SLICE_W-bit ripple adder built from full-adder cells, with carry in/out and MSB carry-in output for overflow), SHALL be instantiated once per stage.
REQ-034 All registers SHALL reside in pipe_adder; adder_slice SHALL be purely combinational.

Verification (WIDTH=16, STAGES=4)
REQ-035 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-036 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x0001, cin=1 -> sum=0x1236.
REQ-037 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-038 Ten back-to-back inputs; out_ready=0 for 3 cycles mid-stream -> in_ready=0 in exactly those cycles, all ten results in order, outputs stable while stalled.
REQ-039 Three inputs in flight, then rst=1 for one cycle -> out_valid=0 after the edge, in_ready=1, none of the three results ever appear.
REQ-040 Random a/b/cin/sub with random in_valid/out_ready over 10k cycles -> every result matches the REQ-016..018 reference model, in order.
